// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/ADD/SUB ALU between two requesters.
// Define ALU_FLAGS_EN to add the registered resp_zero/resp_carry flag outputs.
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic               busy
`ifdef ALU_FLAGS_EN
  ,
  output logic               resp_zero,
  output logic               resp_carry
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_last;
  logic             r_gnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_data;

  logic             w_win;
  logic             w_acc;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;

  // On a tie the requester that did not win last time takes the grant
  assign w_win = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign w_acc = (r_state == S_IDLE) && (req_valid != 2'b00) && !rst;

  assign w_op = w_win ? req_op[3:2] : req_op[1:0];
  assign w_a  = w_win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign w_b  = w_win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_next           = S_EXEC;
          req_ready[w_win] = 1'b1;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        if (resp_ready[r_gnt]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // op[0] selects subtract: a + ~b + 1 shares the adder with ADD
  assign w_bop = r_op[0] ? ~r_b : r_b;
  assign w_sum = {1'b0, r_a} + {1'b0, w_bop}
               + {{WIDTH{1'b0}}, r_op[0]};

  always_comb begin
    w_res = w_sum[WIDTH-1:0];
    unique case (r_op)
      2'b00:   w_res = r_a & r_b;
      2'b01:   w_res = r_a | r_b;
      default: w_res = w_sum[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
      r_gnt  <= 1'b0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_data <= '0;
    end else begin
      if (w_acc) begin
        r_last <= w_win;
        r_gnt  <= w_win;
        r_op   <= w_op;
        r_a    <= w_a;
        r_b    <= w_b;
      end
      if (r_state == S_EXEC) r_data <= w_res;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_zero  <= 1'b0;
      resp_carry <= 1'b0;
    end else if (r_state == S_EXEC) begin
      resp_zero  <= (w_res == '0);
      resp_carry <= r_op[1] & w_sum[WIDTH];
    end
  end
`else
  logic w_unused_carry;
  assign w_unused_carry = w_sum[WIDTH];
`endif

  assign resp_valid = (r_state != S_RESP) ? 2'b00 :
                      (r_gnt ? 2'b10 : 2'b01);
  assign resp_data  = r_data;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (WIDTH=8).
// Flag checks are compiled in only when ALU_FLAGS_EN is defined.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [3:0] req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready = '0;
  logic [7:0] resp_data;
  logic       busy;
`ifdef ALU_FLAGS_EN
  logic       resp_zero;
  logic       resp_carry;
`endif

  int n_run  = 0;
  int n_fail = 0;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
`ifdef ALU_FLAGS_EN
    ,
    .resp_zero  (resp_zero),
    .resp_carry (resp_carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [7:0] a,
                         input logic [7:0] b);
    if (i == 0) begin
      req_op[1:0] = op;
      req_a[7:0]  = a;
      req_b[7:0]  = b;
    end else begin
      req_op[3:2] = op;
      req_a[15:8] = a;
      req_b[15:8] = b;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic finish_resp(input logic [1:0] m);
    resp_ready = m;
    tick();
    resp_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    n_run++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ready got %b exp 00", req_ready);
    end
    n_run++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out got v=%b busy=%b exp 00/0",
               resp_valid, busy);
    end
    n_run++;
    if (resp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_data got %h exp 00", resp_data);
    end
`ifdef ALU_FLAGS_EN
    n_run++;
    if (resp_zero !== 1'b0 || resp_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got z=%b c=%b exp 0/0",
               resp_zero, resp_carry);
    end
`endif
    tick();
    rst = 1'b0;
    #1;
    n_run++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_first_tie got %b exp 01", req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_add();
    do_reset();
    set_req(0, 2'b10, 8'hF0, 8'h20);
    req_valid = 2'b01;
    #1;
    n_run++;
    if (req_ready !== 2'b01 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ready got %b busy=%b exp 01/0",
               req_ready, busy);
    end
    tick();
    req_valid = 2'b00;
    set_req(0, 2'b00, 8'h00, 8'h00);
    #1;
    n_run++;
    if (resp_valid !== 2'b00 || busy !== 1'b1
        || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL add_exec got v=%b b=%b r=%b exp 00/1/00",
               resp_valid, busy, req_ready);
    end
    tick();
    n_run++;
    if (resp_valid !== 2'b01 || resp_data !== 8'h10) begin
      n_fail++;
      $display("FAIL add_resp got v=%b d=%h exp 01/10",
               resp_valid, resp_data);
    end
`ifdef ALU_FLAGS_EN
    n_run++;
    if (resp_carry !== 1'b1 || resp_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_flags got z=%b c=%b exp 0/1",
               resp_zero, resp_carry);
    end
`endif
    finish_resp(2'b01);
    n_run++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done got v=%b b=%b exp 00/0",
               resp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 2'b00, 8'hA5, 8'h0F);
    set_req(1, 2'b01, 8'hA0, 8'h05);
    req_valid = 2'b11;
    #1;
    n_run++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_first got %b exp 01", req_ready);
    end
    tick();
    tick();
    n_run++;
    if (resp_valid !== 2'b01 || resp_data !== 8'h05) begin
      n_fail++;
      $display("FAIL rr_resp0 got v=%b d=%h exp 01/05",
               resp_valid, resp_data);
    end
    finish_resp(2'b01);
    n_run++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_second got %b exp 10", req_ready);
    end
    tick();
    tick();
    n_run++;
    if (resp_valid !== 2'b10 || resp_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL rr_resp1 got v=%b d=%h exp 10/a5",
               resp_valid, resp_data);
    end
    finish_resp(2'b10);
    n_run++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_third got %b exp 01", req_ready);
    end
    req_valid = 2'b00;
    #1;
    n_run++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rr_drop got %b exp 00", req_ready);
    end
    tick();
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drop_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_req(1, 2'b10, 8'h7F, 8'h01);
    req_valid = 2'b10;
    #1;
    tick();
    set_req(0, 2'b01, 8'h11, 8'h22);
    req_valid = 2'b11;
    tick();
    for (int i = 0; i < 10; i++) begin
      resp_ready = (i < 5) ? 2'b00 : 2'b01;
      #1;
      n_run++;
      if (resp_valid !== 2'b10 || resp_data !== 8'h80) begin
        n_fail++;
        $display("FAIL hold_resp[%0d] got v=%b d=%h exp 10/80",
                 i, resp_valid, resp_data);
      end
      n_run++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_busy[%0d] got r=%b b=%b exp 00/1",
                 i, req_ready, busy);
      end
      tick();
    end
    req_valid = 2'b00;
    finish_resp(2'b10);
    n_run++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_done got v=%b b=%b exp 00/0",
               resp_valid, busy);
    end
  endtask

  task automatic test_sub();
    do_reset();
    set_req(0, 2'b11, 8'h03, 8'h05);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    n_run++;
    if (resp_valid !== 2'b01 || resp_data !== 8'hFE) begin
      n_fail++;
      $display("FAIL sub_wrap got v=%b d=%h exp 01/fe",
               resp_valid, resp_data);
    end
`ifdef ALU_FLAGS_EN
    n_run++;
    if (resp_zero !== 1'b0 || resp_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_wrap_flags got z=%b c=%b exp 0/0",
               resp_zero, resp_carry);
    end
`endif
    finish_resp(2'b01);
    set_req(0, 2'b11, 8'h77, 8'h77);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    n_run++;
    if (resp_valid !== 2'b01 || resp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL sub_zero got v=%b d=%h exp 01/00",
               resp_valid, resp_data);
    end
`ifdef ALU_FLAGS_EN
    n_run++;
    if (resp_zero !== 1'b1 || resp_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_zero_flags got z=%b c=%b exp 1/1",
               resp_zero, resp_carry);
    end
`endif
    finish_resp(2'b01);
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req(0, 2'b10, 8'h11, 8'h22);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    n_run++;
    if (busy !== 1'b0 || resp_valid !== 2'b00
        || req_ready !== 2'b00 || resp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rexec_out got b=%b v=%b r=%b d=%h exp 0",
               busy, resp_valid, req_ready, resp_data);
    end
    tick();
    rst = 1'b0;
    set_req(1, 2'b01, 8'h12, 8'h34);
    req_valid = 2'b10;
    #1;
    n_run++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rexec_grant got %b exp 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    n_run++;
    if (resp_valid !== 2'b10 || resp_data !== 8'h36) begin
      n_fail++;
      $display("FAIL rexec_resp got v=%b d=%h exp 10/36",
               resp_valid, resp_data);
    end
    finish_resp(2'b10);
    set_req(0, 2'b10, 8'h11, 8'h22);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    n_run++;
    if (resp_valid !== 2'b01 || resp_data !== 8'h33) begin
      n_fail++;
      $display("FAIL rresp_pre got v=%b d=%h exp 01/33",
               resp_valid, resp_data);
    end
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    n_run++;
    if (busy !== 1'b0 || resp_valid !== 2'b00
        || req_ready !== 2'b00 || resp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rresp_out got b=%b v=%b r=%b d=%h exp 0",
               busy, resp_valid, req_ready, resp_data);
    end
    tick();
    rst = 1'b0;
    req_valid = 2'b10;
    set_req(1, 2'b00, 8'hF3, 8'h3C);
    #1;
    n_run++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rresp_grant got %b exp 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    n_run++;
    if (resp_valid !== 2'b10 || resp_data !== 8'h30) begin
      n_fail++;
      $display("FAIL rresp_resp got v=%b d=%h exp 10/30",
               resp_valid, resp_data);
    end
    finish_resp(2'b10);
  endtask

  task automatic test_busy_reject();
    do_reset();
    set_req(0, 2'b00, 8'hFF, 8'h5A);
    req_valid = 2'b01;
    #1;
    tick();
    set_req(1, 2'b10, 8'h01, 8'h01);
    req_valid = 2'b10;
    #1;
    n_run++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_ready got %b exp 00", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    n_run++;
    if (resp_valid !== 2'b01 || resp_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL busy_resp got v=%b d=%h exp 01/5a",
               resp_valid, resp_data);
    end
    finish_resp(2'b01);
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (resp_valid !== 2'b00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_after[%0d] got v=%b b=%b exp 00/0",
                 i, resp_valid, busy);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_hold();
    test_sub();
    test_reset_mid_op();
    test_busy_reject();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
